// File: rtl/codificador_botoes.sv
// Keyboard front-end: synchronizes and debounces 12 note keys plus right/left/enter
// buttons, then encodes the held note key into a 4-bit code (0 = none, i+1 = key i).
// Latency: a stable input change shows on the outputs DEBOUNCE_CYCLES+4 edges later.
// No flow control: inputs are sampled every cycle and outputs are registered levels.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   botoes[11:0]            raw note keys, active-high
//   right_arrow, left_arrow, enter   raw buttons, active-high
//   botoes_encoded[3:0]     locked note code, 0 when no note is locked
//   *_pressed               debounced button levels
//   multiplas               more than one debounced note key is high
module codificador_botoes #(
  parameter int CLOCK_FREQ      = 50_000_000,
  parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] botoes,
  input  logic        right_arrow,
  input  logic        left_arrow,
  input  logic        enter,
  output logic [3:0]  botoes_encoded,
  output logic        right_arrow_pressed,
  output logic        left_arrow_pressed,
  output logic        enter_pressed,
  output logic        multiplas
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {OCIOSO, TECLA} estado_t;

  logic [14:0] raw;
  assign raw = {enter, left_arrow, right_arrow, botoes};

  logic [14:0]   s1_q, s1_d, s2_q, s2_d;
  logic [14:0]   cand_q, cand_d, deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  estado_t       state_q, state_d;
  logic [3:0]    idx_q, idx_d, enc_q, enc_d;
  logic          mult_q, mult_d;
  logic [2:0]    btn_q, btn_d;

  logic [11:0]   notas;
  logic [3:0]    ones;
  logic          low_vld;
  logic [3:0]    low_idx;

  always_comb begin
    // Synchronizer
    s1_d = raw;
    s2_d = s1_q;

    // Shared debounce window: any bit change restarts it for every bit,
    // and the counter parks at CNT_MAX so it can never wrap.
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    notas = deb_q[11:0];
    btn_d = deb_q[14:12];

    ones = '0;
    for (int i = 0; i < 12; i++) begin
      ones = ones + {3'b000, notas[i]};
    end
    mult_d = (ones > 4'd1);

    // Descending scan so the lowest set index is the one left standing.
    low_vld = 1'b0;
    low_idx = '0;
    for (int i = 11; i >= 0; i--) begin
      if (notas[i]) begin
        low_vld = 1'b1;
        low_idx = 4'(i);
      end
    end

    state_d = state_q;
    idx_d   = idx_q;
    enc_d   = enc_q;
    case (state_q)
      OCIOSO: begin
        if (low_vld) begin
          state_d = TECLA;
          idx_d   = low_idx;
          enc_d   = low_idx + 4'd1;
        end else begin
          enc_d = 4'd0;
        end
      end
      TECLA: begin
        // Other keys are ignored while the locked one is held; on release we
        // always pass through OCIOSO, giving at least one cycle of code 0.
        if (!notas[idx_q]) begin
          state_d = OCIOSO;
          enc_d   = 4'd0;
        end
      end
      default: begin
        state_d = OCIOSO;
        enc_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
      state_q <= OCIOSO;
      idx_q   <= '0;
      enc_q   <= '0;
      mult_q  <= 1'b0;
      btn_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      enc_q   <= enc_d;
      mult_q  <= mult_d;
      btn_q   <= btn_d;
    end
  end

  assign botoes_encoded      = enc_q;
  assign multiplas           = mult_q;
  assign right_arrow_pressed = btn_q[0];
  assign left_arrow_pressed  = btn_q[1];
  assign enter_pressed       = btn_q[2];

endmodule

// File: tb/tb_codificador_botoes.sv
// Bench for codificador_botoes with DEBOUNCE_CYCLES=10 (latency 14 edges).
// A history-window model predicts every output each cycle; directed checks pin timing.
// No flow control involved.
module tb_codificador_botoes;

  localparam int DEB = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] botoes = '0;
  logic        right_arrow = 1'b0;
  logic        left_arrow = 1'b0;
  logic        enter = 1'b0;
  logic [3:0]  botoes_encoded;
  logic        right_arrow_pressed, left_arrow_pressed, enter_pressed, multiplas;

  int n_cmp = 0;
  int n_err = 0;
  bit run = 1'b0;

  codificador_botoes #(.CLOCK_FREQ(1000), .DEBOUNCE_CYCLES(DEB)) dut (
    .clock               (clock),
    .reset               (reset),
    .botoes              (botoes),
    .right_arrow         (right_arrow),
    .left_arrow          (left_arrow),
    .enter               (enter),
    .botoes_encoded      (botoes_encoded),
    .right_arrow_pressed (right_arrow_pressed),
    .left_arrow_pressed  (left_arrow_pressed),
    .enter_pressed       (enter_pressed),
    .multiplas           (multiplas)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: hist[k] is the raw vector seen at the edge k edges ago. The
  // debounced vector takes value X once the raw input has held X for DEB+1
  // consecutive samples, the newest being two edges old (synchronizer delay).
  // Outputs follow the debounced vector one edge later.
  logic [14:0] hist [0:DEB+2];
  logic [14:0] m_d = '0;
  int          m_lock = -1;
  logic [3:0]  m_enc = '0;
  logic        m_mult = 1'b0;
  logic [2:0]  m_btn = '0;

  always begin
    @(posedge clock or posedge reset);
    if (reset) begin
      for (int k = 0; k <= DEB + 2; k++) hist[k] = '0;
      m_d = '0; m_lock = -1; m_enc = '0; m_mult = 1'b0; m_btn = '0;
    end else begin
      bit stable;
      m_btn  = m_d[14:12];
      m_mult = ($countones(m_d[11:0]) > 1);
      if (m_lock < 0) begin
        for (int i = 11; i >= 0; i--) if (m_d[i]) m_lock = i;
      end else if (!m_d[m_lock]) begin
        m_lock = -1;
      end
      m_enc = (m_lock < 0) ? 4'd0 : 4'(m_lock + 1);
      for (int k = DEB + 2; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {enter, left_arrow, right_arrow, botoes};
      stable = 1'b1;
      for (int k = 3; k <= DEB + 2; k++) if (hist[k] != hist[2]) stable = 1'b0;
      if (stable) m_d = hist[2];
    end
  end

  always @(negedge clock) begin
    if (run && !reset) begin
      chk("model_enc",   int'(botoes_encoded),      int'(m_enc));
      chk("model_mult",  int'(multiplas),           int'(m_mult));
      chk("model_right", int'(right_arrow_pressed), int'(m_btn[0]));
      chk("model_left",  int'(left_arrow_pressed),  int'(m_btn[1]));
      chk("model_enter", int'(enter_pressed),       int'(m_btn[2]));
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_arrow(input int which, input logic v);
    if (which == 0) right_arrow = v;
    else            left_arrow  = v;
  endtask

  function automatic int arrow_out(input int which);
    return (which == 0) ? int'(right_arrow_pressed) : int'(left_arrow_pressed);
  endfunction

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_enc",   int'(botoes_encoded), 0);
    chk("rst_mult",  int'(multiplas), 0);
    chk("rst_right", int'(right_arrow_pressed), 0);
    chk("rst_left",  int'(left_arrow_pressed), 0);
    chk("rst_enter", int'(enter_pressed), 0);
    reset = 1'b0;
    run = 1'b1;
    edges(20);

    // 1. Single key
    botoes = 12'h010;
    edges(13); chk("t1_enc_e13", int'(botoes_encoded), 0);
    edges(1);  chk("t1_enc_e14", int'(botoes_encoded), 5);
    edges(10);
    botoes = 12'h000;
    edges(13); chk("t1_rel_e13", int'(botoes_encoded), 5);
    edges(1);  chk("t1_rel_e14", int'(botoes_encoded), 0);
    edges(20);

    // 2. Bounce on key 0, then hold
    for (int i = 0; i < 10; i++) begin
      botoes = (i % 2 == 0) ? 12'h001 : 12'h000;
      edges(3);
      chk("t2_bounce", int'(botoes_encoded), 0);
    end
    botoes = 12'h001;
    edges(13); chk("t2_enc_e13", int'(botoes_encoded), 0);
    edges(1);  chk("t2_enc_e14", int'(botoes_encoded), 1);
    botoes = 12'h000;
    edges(20);

    // 3. Lock and hand-over
    botoes = 12'h004;
    edges(14); chk("t3_enc3", int'(botoes_encoded), 3);
    botoes = 12'h084;
    edges(13); chk("t3_mult_e13", int'(multiplas), 0);
    edges(1);  chk("t3_mult_e14", int'(multiplas), 1);
               chk("t3_enc_held", int'(botoes_encoded), 3);
    botoes = 12'h080;
    edges(13); chk("t3_rel_e13", int'(botoes_encoded), 3);
    edges(1);  chk("t3_gap_enc", int'(botoes_encoded), 0);
               chk("t3_gap_mult", int'(multiplas), 0);
    edges(1);  chk("t3_enc8", int'(botoes_encoded), 8);
    botoes = 12'h000;
    edges(20);

    // 4. Simultaneous press of keys 9 and 3
    botoes = 12'h208;
    edges(13); chk("t4_enc_e13", int'(botoes_encoded), 0);
    edges(1);  chk("t4_enc_e14", int'(botoes_encoded), 4);
               chk("t4_mult", int'(multiplas), 1);
    botoes = 12'h000;
    edges(20);

    // 5. Enter (plus key 5) and asynchronous reset mid-hold
    enter = 1'b1;
    botoes = 12'h020;
    edges(13); chk("t5_enter_e13", int'(enter_pressed), 0);
    edges(1);  chk("t5_enter_e14", int'(enter_pressed), 1);
               chk("t5_enc6", int'(botoes_encoded), 6);
    edges(5);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_enter", int'(enter_pressed), 0);
    chk("t5_rst_enc",   int'(botoes_encoded), 0);
    chk("t5_rst_mult",  int'(multiplas), 0);
    chk("t5_rst_right", int'(right_arrow_pressed), 0);
    chk("t5_rst_left",  int'(left_arrow_pressed), 0);
    @(negedge clock);
    reset = 1'b0;
    edges(13); chk("t5_again_e13", int'(enter_pressed), 0);
    edges(1);  chk("t5_again_e14", int'(enter_pressed), 1);
               chk("t5_again_enc", int'(botoes_encoded), 6);
    enter = 1'b0;
    botoes = 12'h000;
    edges(20);

    // 6. Arrows: 8-cycle glitch, then a 20-cycle press
    for (int w = 0; w < 2; w++) begin
      set_arrow(w, 1'b1);
      edges(8);
      set_arrow(w, 1'b0);
      for (int c = 0; c < 24; c++) begin
        edges(1);
        chk("t6_glitch", arrow_out(w), 0);
      end
      set_arrow(w, 1'b1);
      edges(13); chk("t6_press_e13", arrow_out(w), 0);
      edges(1);  chk("t6_press_e14", arrow_out(w), 1);
      edges(6);
      set_arrow(w, 1'b0);
      edges(13); chk("t6_press_e33", arrow_out(w), 1);
      edges(1);  chk("t6_press_e34", arrow_out(w), 0);
      edges(20);
    end

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
